// File: rtl/pm_pkg.sv
// Pacman motion controller: shared direction type, maze geometry and pixel/grid helpers.
package pm_pkg;

    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        LEFT  = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    localparam int unsigned ORIGIN_X = 110;
    localparam int unsigned ORIGIN_Y = 8;
    localparam int unsigned CELL     = 15;
    localparam int unsigned GRID_W   = 28;
    localparam int unsigned GRID_H   = 31;
    localparam int unsigned SPRITE   = 26;
    // Sprite top-left when centred on cell 0 (104, 2).
    localparam int unsigned ALIGN_X0 = ORIGIN_X + CELL / 2 - SPRITE / 2;
    localparam int unsigned ALIGN_Y0 = ORIGIN_Y + CELL / 2 - SPRITE / 2;

    function automatic dir_t opposite(input dir_t d);
        dir_t r;
        case (d)
            RIGHT:   r = LEFT;
            LEFT:    r = RIGHT;
            UP:      r = DOWN;
            default: r = UP;
        endcase
        return r;
    endfunction

    function automatic logic [9:0] cell_x(input logic [4:0] g);
        return 10'(ALIGN_X0 + CELL * 32'(g));
    endfunction

    function automatic logic [9:0] cell_y(input logic [4:0] g);
        return 10'(ALIGN_Y0 + CELL * 32'(g));
    endfunction

endpackage

// File: rtl/pm_anim.sv
// Ping-pong animation sequencer: frame walks 0,1,2,1,0,... advancing once every ANIM_DIV steps.
module pm_anim #(
    parameter int unsigned ANIM_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       step,
    output logic [1:0] frame
);

    logic [7:0] cnt_q, cnt_d;
    logic [1:0] frame_q, frame_d;
    logic       up_q, up_d;

    always_comb begin
        cnt_d   = cnt_q;
        frame_d = frame_q;
        up_d    = up_q;
        if (enable && step) begin
            if (cnt_q == 8'(ANIM_DIV - 1)) begin
                cnt_d = '0;
                if (up_q) begin
                    frame_d = frame_q + 2'd1;
                    if (frame_q == 2'd1) up_d = 1'b0;
                end else begin
                    frame_d = frame_q - 2'd1;
                    if (frame_q == 2'd1) up_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            frame_q <= '0;
            up_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            up_q    <= up_d;
        end
    end

    assign frame = frame_q;

endmodule

// File: rtl/pm_mover.sv
// Pacman motion controller: advances the sprite one pixel per step through the maze, checking
// turns at cell centres against a synchronous wall ROM.
module pm_mover
    import pm_pkg::*;
#(
    parameter int unsigned START_GX        = 13,
    parameter int unsigned START_GY        = 23,
    parameter int unsigned FRAMES_PER_STEP = 1,
    parameter int unsigned ANIM_DIV        = 4,
    parameter int unsigned TUNNEL_ROW      = 14
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        dir_req_valid,
    input  logic [1:0]  dir_req,
    output logic [9:0]  wall_addr,
    input  logic        wall_q,
    output logic [31:0] pm_x,
    output logic [31:0] pm_y,
    output logic [31:0] pm_dir,
    output logic [1:0]  pm_frame,
    output logic [4:0]  pm_gx,
    output logic [4:0]  pm_gy,
    output logic        cell_arrive,
    output logic        moving
);

    typedef enum logic [2:0] {StIdle, StReqRd, StReqChk, StCurRd, StCurChk} state_t;

    state_t     state_q, state_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [4:0] gx_q, gx_d, gy_q, gy_d;
    dir_t       dir_q, dir_d, req_q, mv_dir, nb_dir;
    logic       moving_q, moving_d, arrive_q, arrive_d;
    logic [9:0] addr_q, addr_d;
    logic       blocked_q, blocked_d, wrap_q, wrap_d;
    logic [4:0] nb_gx_q, nb_gx_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic       step, aligned, load_nb, do_move;
    logic [4:0] nb_gx, nb_gy;
    logic       nb_out, nb_wrap;

    assign aligned = (x_q == cell_x(gx_q)) && (y_q == cell_y(gy_q));

    // Ticks arriving while a step is in flight are dropped, not counted.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        step       = 1'b0;
        if (frame_tick && state_q == StIdle) begin
            if (tick_cnt_q == 4'(FRAMES_PER_STEP - 1)) begin
                tick_cnt_d = '0;
                step       = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 4'd1;
            end
        end
    end

    assign nb_dir = (state_q == StIdle) ? req_q : dir_q;

    always_comb begin
        nb_gx   = gx_q;
        nb_gy   = gy_q;
        nb_out  = 1'b0;
        nb_wrap = 1'b0;
        unique case (nb_dir)
            RIGHT: begin
                if (gx_q == 5'(GRID_W - 1)) begin
                    if (gy_q == 5'(TUNNEL_ROW)) begin
                        nb_gx   = '0;
                        nb_wrap = 1'b1;
                    end else begin
                        nb_out = 1'b1;
                    end
                end else begin
                    nb_gx = gx_q + 5'd1;
                end
            end
            LEFT: begin
                if (gx_q == '0) begin
                    if (gy_q == 5'(TUNNEL_ROW)) begin
                        nb_gx   = 5'(GRID_W - 1);
                        nb_wrap = 1'b1;
                    end else begin
                        nb_out = 1'b1;
                    end
                end else begin
                    nb_gx = gx_q - 5'd1;
                end
            end
            UP: begin
                if (gy_q == '0) nb_out = 1'b1;
                else            nb_gy  = gy_q - 5'd1;
            end
            DOWN: begin
                if (gy_q == 5'(GRID_H - 1)) nb_out = 1'b1;
                else                        nb_gy  = gy_q + 5'd1;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        gx_d      = gx_q;
        gy_d      = gy_q;
        dir_d     = dir_q;
        moving_d  = moving_q;
        arrive_d  = 1'b0;
        addr_d    = addr_q;
        blocked_d = blocked_q;
        wrap_d    = wrap_q;
        nb_gx_d   = nb_gx_q;
        load_nb   = 1'b0;
        do_move   = 1'b0;
        mv_dir    = dir_q;

        unique case (state_q)
            StIdle: begin
                if (step) begin
                    if (aligned) begin
                        state_d = StReqRd;
                        load_nb = 1'b1;
                    end else begin
                        // Mid-cell only an immediate reversal is allowed; it needs no ROM check.
                        if (req_q == opposite(dir_q)) dir_d = req_q;
                        mv_dir  = dir_d;
                        do_move = 1'b1;
                    end
                end
            end
            StReqRd: state_d = StReqChk;
            StReqChk: begin
                if (blocked_q || wall_q) begin
                    state_d = StCurRd;
                    load_nb = 1'b1;
                end else begin
                    state_d = StIdle;
                    dir_d   = req_q;
                    mv_dir  = req_q;
                    do_move = 1'b1;
                end
            end
            StCurRd: state_d = StCurChk;
            StCurChk: begin
                state_d = StIdle;
                if (blocked_q || wall_q) moving_d = 1'b0;
                else                     do_move  = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (load_nb) begin
            blocked_d = nb_out;
            wrap_d    = nb_wrap;
            nb_gx_d   = nb_gx;
            if (!nb_out) addr_d = 10'(32'(nb_gy) * GRID_W + 32'(nb_gx));
        end

        if (do_move) begin
            moving_d = 1'b1;
            if (state_q != StIdle && wrap_q) begin
                x_d      = cell_x(nb_gx_q);
                gx_d     = nb_gx_q;
                arrive_d = 1'b1;
            end else begin
                unique case (mv_dir)
                    RIGHT: x_d = x_q + 10'd1;
                    LEFT:  x_d = x_q - 10'd1;
                    UP:    y_d = y_q - 10'd1;
                    DOWN:  y_d = y_q + 10'd1;
                endcase
                // A one-pixel move can only land on the home cell or an adjacent one.
                if (y_d == cell_y(gy_q)) begin
                    if (x_d == cell_x(gx_q)) begin
                        arrive_d = 1'b1;
                    end else if (x_d == cell_x(gx_q + 5'd1)) begin
                        arrive_d = 1'b1;
                        gx_d     = gx_q + 5'd1;
                    end else if (x_d == cell_x(gx_q - 5'd1)) begin
                        arrive_d = 1'b1;
                        gx_d     = gx_q - 5'd1;
                    end
                end else if (x_d == cell_x(gx_q)) begin
                    if (y_d == cell_y(gy_q + 5'd1)) begin
                        arrive_d = 1'b1;
                        gy_d     = gy_q + 5'd1;
                    end else if (y_d == cell_y(gy_q - 5'd1)) begin
                        arrive_d = 1'b1;
                        gy_d     = gy_q - 5'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            x_q        <= cell_x(5'(START_GX));
            y_q        <= cell_y(5'(START_GY));
            gx_q       <= 5'(START_GX);
            gy_q       <= 5'(START_GY);
            dir_q      <= LEFT;
            req_q      <= LEFT;
            moving_q   <= 1'b0;
            arrive_q   <= 1'b0;
            addr_q     <= '0;
            blocked_q  <= 1'b0;
            wrap_q     <= 1'b0;
            nb_gx_q    <= '0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            gx_q       <= gx_d;
            gy_q       <= gy_d;
            dir_q      <= dir_d;
            moving_q   <= moving_d;
            arrive_q   <= arrive_d;
            addr_q     <= addr_d;
            blocked_q  <= blocked_d;
            wrap_q     <= wrap_d;
            nb_gx_q    <= nb_gx_d;
            tick_cnt_q <= tick_cnt_d;
            if (dir_req_valid) req_q <= dir_t'(dir_req);
        end
    end

    pm_anim #(
        .ANIM_DIV(ANIM_DIV)
    ) u_anim (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .enable(moving_d),
        .step  (do_move),
        .frame (pm_frame)
    );

    assign wall_addr   = addr_q;
    assign pm_x        = {22'd0, x_q};
    assign pm_y        = {22'd0, y_q};
    assign pm_dir      = {30'd0, dir_q};
    assign pm_gx       = gx_q;
    assign pm_gy       = gy_q;
    assign cell_arrive = arrive_q;
    assign moving      = moving_q;

endmodule

// File: tb/tb_pm_mover.sv
// Bench for pm_mover: wall ROM model, pixel-level behavioural model and a per-step scoreboard.
module tb_pm_mover;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        dir_req_valid = 1'b0;
    logic [1:0]  dir_req = 2'd0;
    logic [9:0]  wall_addr;
    logic        wall_q = 1'b0;
    logic [31:0] pm_x, pm_y, pm_dir;
    logic [1:0]  pm_frame;
    logic [4:0]  pm_gx, pm_gy;
    logic        cell_arrive, moving;

    always #5 clk = ~clk;

    pm_mover dut (
        .vga_clk      (clk),
        .reset_n      (reset_n),
        .frame_tick   (frame_tick),
        .dir_req_valid(dir_req_valid),
        .dir_req      (dir_req),
        .wall_addr    (wall_addr),
        .wall_q       (wall_q),
        .pm_x         (pm_x),
        .pm_y         (pm_y),
        .pm_dir       (pm_dir),
        .pm_frame     (pm_frame),
        .pm_gx        (pm_gx),
        .pm_gy        (pm_gy),
        .cell_arrive  (cell_arrive),
        .moving       (moving)
    );

    logic walls [0:1023];
    always @(posedge clk) wall_q <= walls[wall_addr];

    int arr_cnt = 0;
    always @(negedge clk) if (cell_arrive) arr_cnt++;

    typedef struct {
        int x; int y; int dir; int frame; int gx; int gy; int mov; int arr;
    } exp_t;
    exp_t sb[$];
    event step_done;
    int compared = 0;
    int mismatched = 0;
    int step_id = 0;

    int mx, my, mdir, mreq, mgx, mgy, mmoves, marr;
    bit mmoving;

    function automatic int opp(int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int frame_seq(int n);
        int k;
        k = (n / 4) % 4;
        return (k == 3) ? 1 : k;
    endfunction

    function automatic bit nb_open(int d);
        int gx, gy;
        gx = (mx - 104) / 15;
        gy = (my - 2) / 15;
        case (d)
            0: if (gx == 27) return (gy == 14) && !walls[gy * 28];
               else return !walls[gy * 28 + gx + 1];
            1: if (gx == 0) return (gy == 14) && !walls[gy * 28 + 27];
               else return !walls[gy * 28 + gx - 1];
            2: if (gy == 0) return 1'b0;
               else return !walls[(gy - 1) * 28 + gx];
            default: if (gy == 30) return 1'b0;
                     else return !walls[(gy + 1) * 28 + gx];
        endcase
    endfunction

    task automatic model_init();
        mx = 299; my = 347; mdir = 1; mreq = 1; mgx = 13; mgy = 23;
        mmoves = 0; mmoving = 1'b0; marr = arr_cnt;
    endtask

    task automatic model_step();
        bit al, moved;
        int gx;
        exp_t e;
        al = ((mx - 104) % 15 == 0) && ((my - 2) % 15 == 0);
        gx = (mx - 104) / 15;
        moved = 1'b0;
        if (!al) begin
            if (mreq == opp(mdir)) mdir = mreq;
            moved = 1'b1;
        end else if (nb_open(mreq)) begin
            mdir = mreq;
            moved = 1'b1;
        end else if (nb_open(mdir)) begin
            moved = 1'b1;
        end else begin
            mmoving = 1'b0;
        end
        if (moved) begin
            mmoving = 1'b1;
            mmoves++;
            if (al && mdir == 1 && gx == 0) mx = 509;
            else if (al && mdir == 0 && gx == 27) mx = 104;
            else begin
                case (mdir)
                    0: mx++;
                    1: mx--;
                    2: my--;
                    default: my++;
                endcase
            end
            if ((mx - 104) % 15 == 0 && (my - 2) % 15 == 0) begin
                marr++;
                mgx = (mx - 104) / 15;
                mgy = (my - 2) / 15;
            end
        end
        e.x = mx; e.y = my; e.dir = mdir; e.frame = frame_seq(mmoves);
        e.gx = mgx; e.gy = mgy; e.mov = int'(mmoving); e.arr = marr;
        sb.push_back(e);
    endtask

    always @(step_done) begin
        exp_t e;
        step_id++;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL sb_empty step%0d: got no expectation, want one", step_id);
        end else begin
            e = sb.pop_front();
            if (pm_x !== e.x || pm_y !== e.y) begin
                mismatched++;
                $display("FAIL step%0d pos: got (%0d,%0d) want (%0d,%0d)",
                         step_id, pm_x, pm_y, e.x, e.y);
            end
            compared++;
            if (pm_dir !== e.dir) begin
                mismatched++;
                $display("FAIL step%0d pm_dir: got %0d want %0d", step_id, pm_dir, e.dir);
            end
            compared++;
            if (pm_frame !== e.frame) begin
                mismatched++;
                $display("FAIL step%0d pm_frame: got %0d want %0d", step_id, pm_frame, e.frame);
            end
            compared++;
            if (pm_gx !== e.gx || pm_gy !== e.gy) begin
                mismatched++;
                $display("FAIL step%0d grid: got (%0d,%0d) want (%0d,%0d)",
                         step_id, pm_gx, pm_gy, e.gx, e.gy);
            end
            compared++;
            if (moving !== e.mov) begin
                mismatched++;
                $display("FAIL step%0d moving: got %0d want %0d", step_id, moving, e.mov);
            end
            compared++;
            if (arr_cnt !== e.arr) begin
                mismatched++;
                $display("FAIL step%0d cell_arrive count: got %0d want %0d",
                         step_id, arr_cnt, e.arr);
            end
        end
    end

    task automatic clear_maze();
        for (int i = 0; i < 1024; i++) walls[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        frame_tick = 1'b0;
        dir_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_init();
    endtask

    task automatic set_req(input int d);
        @(negedge clk);
        dir_req_valid = 1'b1;
        dir_req = 2'(d);
        mreq = d;
        @(negedge clk);
        dir_req_valid = 1'b0;
    endtask

    task automatic tick_step();
        @(negedge clk);
        frame_tick = 1'b1;
        model_step();
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (7) @(negedge clk);
        -> step_done;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick_step();
    endtask

    task automatic test_reset();
        clear_maze();
        do_reset();
        compared++;
        if (pm_x !== 299 || pm_y !== 347) begin
            mismatched++;
            $display("FAIL reset_pos: got (%0d,%0d) want (299,347)", pm_x, pm_y);
        end
        compared++;
        if (pm_dir !== 1 || pm_frame !== 0 || moving !== 0 || cell_arrive !== 0) begin
            mismatched++;
            $display("FAIL reset_flags: got dir=%0d frame=%0d moving=%0d arrive=%0d want 1,0,0,0",
                     pm_dir, pm_frame, moving, cell_arrive);
        end
        compared++;
        if (wall_addr !== 0 || pm_gx !== 13 || pm_gy !== 23) begin
            mismatched++;
            $display("FAIL reset_grid: got addr=%0d gx=%0d gy=%0d want 0,13,23",
                     wall_addr, pm_gx, pm_gy);
        end
    endtask

    task automatic test_corridor();
        int a0;
        clear_maze();
        do_reset();
        a0 = arr_cnt;
        set_req(1);
        run_ticks(4);
        compared++;
        if (pm_frame !== 1) begin
            mismatched++;
            $display("FAIL corridor_frame4: got %0d want 1", pm_frame);
        end
        run_ticks(4);
        compared++;
        if (pm_frame !== 2) begin
            mismatched++;
            $display("FAIL corridor_frame8: got %0d want 2", pm_frame);
        end
        run_ticks(7);
        compared++;
        if (pm_x !== 284 || pm_gx !== 12 || arr_cnt - a0 !== 1) begin
            mismatched++;
            $display("FAIL corridor_end: got x=%0d gx=%0d arrivals=%0d want 284,12,1",
                     pm_x, pm_gx, arr_cnt - a0);
        end
    endtask

    task automatic test_wall();
        clear_maze();
        walls[23 * 28 + 12] = 1'b1;
        do_reset();
        set_req(1);
        run_ticks(20);
        compared++;
        if (pm_x !== 299 || moving !== 0 || wall_addr !== 656) begin
            mismatched++;
            $display("FAIL wall_stop: got x=%0d moving=%0d addr=%0d want 299,0,656",
                     pm_x, moving, wall_addr);
        end
    endtask

    task automatic test_turn();
        clear_maze();
        do_reset();
        set_req(1);
        run_ticks(10);
        set_req(2);
        run_ticks(5);
        compared++;
        if (pm_x !== 284 || pm_y !== 347 || pm_dir !== 1) begin
            mismatched++;
            $display("FAIL turn_align: got x=%0d y=%0d dir=%0d want 284,347,1", pm_x, pm_y, pm_dir);
        end
        tick_step();
        compared++;
        if (pm_x !== 284 || pm_y !== 346 || pm_dir !== 2) begin
            mismatched++;
            $display("FAIL turn_up: got x=%0d y=%0d dir=%0d want 284,346,2", pm_x, pm_y, pm_dir);
        end
    endtask

    task automatic test_reverse();
        clear_maze();
        do_reset();
        set_req(1);
        run_ticks(5);
        set_req(0);
        tick_step();
        compared++;
        if (pm_dir !== 0 || pm_x !== 295 || wall_addr !== 656) begin
            mismatched++;
            $display("FAIL reverse: got dir=%0d x=%0d addr=%0d want 0,295,656",
                     pm_dir, pm_x, wall_addr);
        end
    endtask

    task automatic test_tunnel_and_reset();
        int a0;
        clear_maze();
        do_reset();
        set_req(2);
        run_ticks(135);
        set_req(1);
        run_ticks(195);
        compared++;
        if (pm_x !== 104 || pm_y !== 212 || pm_gx !== 0 || pm_gy !== 14) begin
            mismatched++;
            $display("FAIL tunnel_edge: got (%0d,%0d) cell (%0d,%0d) want (104,212) (0,14)",
                     pm_x, pm_y, pm_gx, pm_gy);
        end
        a0 = arr_cnt;
        tick_step();
        compared++;
        if (pm_x !== 509 || pm_gx !== 27 || arr_cnt - a0 !== 1) begin
            mismatched++;
            $display("FAIL tunnel_wrap: got x=%0d gx=%0d arrivals=%0d want 509,27,1",
                     pm_x, pm_gx, arr_cnt - a0);
        end
        // Start a step, then reset while it waits on the ROM.
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        compared++;
        if (wall_addr !== 418) begin
            mismatched++;
            $display("FAIL midstep_addr: got %0d want 418", wall_addr);
        end
        reset_n = 1'b0;
        #1;
        compared++;
        if (pm_x !== 299 || pm_y !== 347 || pm_dir !== 1 || pm_frame !== 0 || moving !== 0
            || wall_addr !== 0 || pm_gx !== 13 || pm_gy !== 23) begin
            mismatched++;
            $display("FAIL midstep_reset: got (%0d,%0d) dir=%0d frame=%0d mov=%0d addr=%0d",
                     pm_x, pm_y, pm_dir, pm_frame, moving, wall_addr);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_init();
        tick_step();
    endtask

    task automatic test_back_to_back();
        clear_maze();
        do_reset();
        @(negedge clk);
        frame_tick = 1'b1;
        model_step();
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (6) @(negedge clk);
        -> step_done;
        @(negedge clk);
        compared++;
        if (pm_x !== 298) begin
            mismatched++;
            $display("FAIL back_to_back: got x=%0d want 298", pm_x);
        end
    endtask

    initial begin
        test_reset();
        test_corridor();
        test_wall();
        test_turn();
        test_reverse();
        test_tunnel_and_reset();
        test_back_to_back();
        @(negedge clk);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
